// File: rtl/verisoc_pkg.sv
// Shared Wishbone definitions for the VeriSoC bus fabric: bus widths, arbiter
// state encoding and the default response word used for dead or aborted accesses.
package verisoc_pkg;

    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_SELW = 4;

    localparam logic [WB_DW-1:0] WB_DEADBEEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } wb_arb_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at or
// after ptr, scanning upward with wrap-around.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             valid
);

    // Walk the N candidate slots starting at ptr; the first live request wins.
    always_comb begin
        logic [PTR_W:0]   pos;
        logic [PTR_W-1:0] idx;
        logic             hit;
        gnt   = '0;
        valid = 1'b0;
        pos   = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            pos      = {1'b0, ptr} + (PTR_W+1)'(i);
            pos      = (pos >= (PTR_W+1)'(N)) ? pos - (PTR_W+1)'(N) : pos;
            idx      = pos[PTR_W-1:0];
            hit      = req[idx] & ~valid;
            gnt[idx] = gnt[idx] | hit;
            valid    = valid | hit;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter with a bus watchdog that terminates stalled slave
// accesses with an error-data ack so the granted master never hangs.
module wb_rr_arbiter
    import verisoc_pkg::*;
#(
    parameter int unsigned      NUM_MASTERS    = 2,
    parameter int unsigned      TIMEOUT_CYCLES = 255,
    parameter logic [WB_DW-1:0] TIMEOUT_DATA   = WB_DEADBEEF
) (
    input  logic                           wb_clk,
    input  logic                           wb_rst_n,
    input  logic [WB_AW*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [WB_DW*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [WB_SELW*NUM_MASTERS-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]         m_we_i,
    input  logic [NUM_MASTERS-1:0]         m_cyc_i,
    input  logic [NUM_MASTERS-1:0]         m_stb_i,
    output logic [WB_DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]         m_ack_o,
    output logic [WB_AW-1:0]               s_adr_o,
    output logic [WB_DW-1:0]               s_dat_o,
    output logic [WB_SELW-1:0]             s_sel_o,
    output logic                           s_we_o,
    output logic                           s_cyc_o,
    output logic                           s_stb_o,
    input  logic [WB_DW-1:0]               s_dat_i,
    input  logic                           s_ack_i,
    output logic [NUM_MASTERS-1:0]         grant_o,
    output logic                           timeout_o,
    output logic [7:0]                     timeout_cnt_o
);

    localparam int unsigned     PTR_W   = $clog2(NUM_MASTERS);
    localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic            WD_EN   = (TIMEOUT_CYCLES > 0);

    wb_arb_state_e          state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]       gidx_q, gidx_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic [7:0]             tcnt_q, tcnt_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic                   pick_valid;
    logic [PTR_W-1:0]       pick_idx;

    logic [WB_AW-1:0]       g_adr;
    logic [WB_DW-1:0]       g_dat;
    logic [WB_SELW-1:0]     g_sel;
    logic                   g_we;
    logic                   g_cyc;
    logic                   g_stb;

    rr_pick #(
        .N     (NUM_MASTERS),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (m_cyc_i),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // One-hot pick result to binary master index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            pick_idx = pick_idx | (pick_gnt[k] ? PTR_W'(k) : '0);
        end
    end

    // Select the granted master's bus signals.
    always_comb begin
        logic sel;
        sel   = 1'b0;
        g_adr = '0;
        g_dat = '0;
        g_sel = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            sel   = (gidx_q == PTR_W'(k));
            g_adr = g_adr | ({WB_AW{sel}}   & m_adr_i[k*WB_AW +: WB_AW]);
            g_dat = g_dat | ({WB_DW{sel}}   & m_dat_i[k*WB_DW +: WB_DW]);
            g_sel = g_sel | ({WB_SELW{sel}} & m_sel_i[k*WB_SELW +: WB_SELW]);
            g_we  = g_we  | (sel & m_we_i[k]);
            g_cyc = g_cyc | (sel & m_cyc_i[k]);
            g_stb = g_stb | (sel & m_stb_i[k]);
        end
    end

    // Next-state: arbitration, tenure release, watchdog and abort accounting.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        wd_cnt_d = wd_cnt_q;
        tcnt_d   = tcnt_q;
        case (state_q)
            IDLE: begin
                wd_cnt_d = '0;
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                end else begin
                    grant_d = '0;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    gidx_d   = '0;
                    wd_cnt_d = '0;
                    rr_ptr_d = (gidx_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + PTR_W'(1);
                end else if (s_ack_i) begin
                    wd_cnt_d = '0;
                end else if (g_stb) begin
                    // Ack has priority above, so a late ack on the limit cycle never aborts.
                    if (WD_EN && (wd_cnt_q == WD_LAST)) begin
                        state_d  = ABORT;
                        wd_cnt_d = '0;
                    end else begin
                        wd_cnt_d = wd_cnt_q + WD_W'(1);
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q;
                end
            end
            ABORT: begin
                state_d = BUSY;
                tcnt_d  = sat_inc8(tcnt_q);
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                gidx_d   = '0;
                wd_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset also drops the slave cycle mid-tenure.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            tcnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            wd_cnt_q <= wd_cnt_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Bus muxing; during the abort cycle the slave strobe is withheld.
    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m_ack_o   = '0;
        m_dat_o   = '0;
        timeout_o = 1'b0;
        case (state_q)
            BUSY: begin
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                s_sel_o = g_sel;
                s_we_o  = g_we;
                s_cyc_o = g_cyc;
                s_stb_o = g_stb;
                m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
                m_dat_o = s_dat_i;
            end
            ABORT: begin
                s_adr_o   = g_adr;
                s_dat_o   = g_dat;
                s_sel_o   = g_sel;
                s_we_o    = g_we;
                s_cyc_o   = g_cyc;
                s_stb_o   = 1'b0;
                m_ack_o   = grant_q;
                m_dat_o   = TIMEOUT_DATA;
                timeout_o = 1'b1;
            end
            default: begin
                m_dat_o = '0;
            end
        endcase
    end

    assign grant_o       = grant_q;
    assign timeout_cnt_o = tcnt_q;

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that shares the single SoC Wishbone bus between up to NUM_MASTERS requesters: the picorv32 core plus future DMA or debug masters. It sits between the masters and the existing address decode of the RAM, external-WB and AHB-bridge slaves. It grants one master per bus tenure, which lasts while that master holds cyc. It also owns a bus watchdog: a stalled slave access is terminated with an error-data ack instead of hanging the CPU.

## Interface
- NUM_MASTERS, 2: number of requesters, 2..4.
- TIMEOUT_CYCLES, 255: stb-without-ack cycles before abort; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned on an aborted access.

- wb_clk  in  1  bus clock; all logic on its rising edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- m_adr_i  in  32*NUM_MASTERS  master addresses, master k at bits [32k+31:32k].
- m_dat_i  in  32*NUM_MASTERS  master write data.
- m_sel_i  in  4*NUM_MASTERS  byte selects.
- m_we_i / m_cyc_i / m_stb_i  in  NUM_MASTERS each  per-master write, cycle and strobe.
- m_dat_o  out  32  shared read data; valid only with the matching m_ack_o bit.
- m_ack_o  out  NUM_MASTERS  per-master ack.
- s_adr_o / s_dat_o  out  32  to slave decode.
- s_sel_o  out  4  to slave decode.
- s_we_o / s_cyc_o / s_stb_o  out  1  to slave decode.
- s_dat_i  in  32  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  NUM_MASTERS  one-hot current owner; all-zero when idle.
- timeout_o  out  1  one-cycle pulse on each watchdog abort.
- timeout_cnt_o  out  8  abort count, saturates at 255.

## Operation
- States: IDLE, BUSY, ABORT.
- IDLE:
  - If any m_cyc_i is high, pick the first requester at or after rr_ptr, scanning upward with wrap. Register it into grant_o and go to BUSY.
  - No request: stay in IDLE with grant_o = 0.
- BUSY: slave outputs are a combinational mux of the granted master's signals.
  - s_cyc_o = m_cyc_i[g] and s_stb_o = m_stb_i[g].
  - m_ack_o[g] = s_ack_i; every other ack bit is 0.
  - m_dat_o = s_dat_i.
  - Multiple stb/ack beats within one cyc tenure are legal; the grant is held for all of them.
- Release: when m_cyc_i[g] drops in BUSY, s_cyc_o and s_stb_o drop the same cycle (combinational). Next cycle: state IDLE, grant_o = 0, rr_ptr = g+1 mod NUM_MASTERS.
- Watchdog:
  - wd_cnt increments each BUSY cycle with s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i, on release, or on entering ABORT.
  - When wd_cnt reaches TIMEOUT_CYCLES-1 and the cycle has stb high without ack, go to ABORT.
- ABORT (exactly 1 cycle):
  - s_stb_o = 0, m_ack_o[g] = 1, m_dat_o = TIMEOUT_DATA, timeout_o = 1, timeout_cnt_o increments (saturating).
  - Then return to BUSY with the same grant; the master decides whether to drop cyc.
- Non-granted masters see ack = 0 and simply wait; there is no retry or error signalling to them.

## Timing
- Arbitration latency: 1 cycle from m_cyc_i rise (in IDLE) to s_cyc_o high. Re-arbitration after a release costs 1 idle cycle.
- Reset values: state IDLE, grant_o 0, rr_ptr 0, s_cyc_o/s_stb_o/s_we_o 0, s_adr_o/s_dat_o/s_sel_o 0, m_ack_o 0, m_dat_o 0, timeout_o 0, timeout_cnt_o 0, wd_cnt 0.
- Reset mid-tenure: all of the above take effect immediately (asynchronous); s_cyc_o drops without waiting for ack.
- s_ack_i arriving on the cycle the watchdog would fire: the ack wins, there is no abort, and wd_cnt clears.
- s_ack_i while in ABORT is ignored and is not forwarded.
- Requests from several masters in the same IDLE cycle: rr_ptr alone decides the winner. No master waits more than NUM_MASTERS-1 tenures.
- The granted master dropping cyc in the same cycle as s_ack_i: the ack is forwarded, and release happens the same cycle.

## Structure
- Shared package verisoc_pkg holds:
  - WB_AW=32, WB_DW=32, WB_SELW=4.
  - The state enum {IDLE, BUSY, ABORT}.
  - The DEADBEEF default constant, which the bus-default response in the top level also uses.
- Sub-module rr_pick: combinational priority picker with inputs req[N] and ptr, outputs one-hot gnt and valid.
- The arbiter contains the FSM, rr_ptr, the watchdog and the muxes.

## Test plan
- Single master: CPU read to 0x0000_0010 while RAM acks after 1 cycle. Expect s_cyc_o 1 cycle after m_cyc_i, m_ack_o=2'b01, and RAM data returned; grant_o returns to 0 one cycle after cyc drops.
- Contention: both masters raise cyc in the same cycle from reset. Expect master 0 granted first and master 1 next, with one idle cycle between; with both re-requesting continuously, grants alternate 0,1,0,1.
- Tenure hold: master 0 runs three stb/ack beats in one cyc while master 1 requests throughout. Expect master 1 to receive no ack until master 0 drops cyc.
- Watchdog: TIMEOUT_CYCLES=8, slave never acks. Expect ack to the master with data 32'hDEADBEEF on the 9th stb cycle, timeout_o high for exactly 1 cycle, and timeout_cnt_o=1. Repeat 300 times and expect timeout_cnt_o to saturate at 255.
- Race: ack arrives exactly on the would-be abort cycle. Expect the slave data to be forwarded and timeout_o to stay 0.
- Reset: assert wb_rst_n=0 mid-BUSY. Expect s_cyc_o, grant_o and m_ack_o to go to 0 asynchronously, and rr_ptr=0 after release.
